// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// IF looks up lookup_pc combinationally; EX commits resolved outcomes via the update port.
// Optional macro BTB_STATS_EN adds update and mispredict statistics counters.
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_next_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispredict,
  input  logic            inv_all
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_upd_cnt,
  output logic [31:0]     stat_mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_commit;
  logic             unused_bits;

  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign lookup_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign upd_idx    = upd_pc[IDX_W+1:2];
  assign upd_tag    = upd_pc[XLEN-1:IDX_W+2];

  // pc[1:0] is never used for indexing; the mispredict flag only feeds the stats option
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};

  // Combinational lookup: reads pre-update contents, no bypass from the update port
  always_comb begin
    pred_hit     = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    pred_taken   = pred_hit && ctr_q[lookup_idx][CTR_W-1];
    pred_next_pc = pred_taken ? target_q[lookup_idx] : lookup_pc + XLEN'(4);
  end

  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_commit = upd_valid && !reset && !inv_all;

  // Valid bits and direction counters: reset beats invalidate, which beats update
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + 1'b1;
        end else begin
          if (ctr_q[upd_idx] != '0) ctr_q[upd_idx] <= ctr_q[upd_idx] - 1'b1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_WEAK;
      end
    end
  end

  // Tag and target payload: written on every committed taken outcome (refresh on hit, allocate on miss)
  always_ff @(posedge clk) begin
    if (upd_commit && upd_taken) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
    end
  end

`ifdef BTB_STATS_EN
  // Saturating statistics counters, cleared by reset only and blind to inv_all
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_upd_cnt     <= '0;
      stat_mispred_cnt <= '0;
    end else if (upd_valid) begin
      if (stat_upd_cnt != 32'hFFFF_FFFF) stat_upd_cnt <= stat_upd_cnt + 32'd1;
      if (upd_mispredict && (stat_mispred_cnt != 32'hFFFF_FFFF))
        stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule
